// File: rtl/ext_pkg.sv
// ext_pkg: shared op encoding, skid buffer states and the extend function
// used by ext_unit. The function works on a 64-bit canvas; callers pass
// their real widths and keep the low DATA_W bits plus the error flag.
package ext_pkg;

   typedef enum logic [2:0] {
      EXT_SIGN = 3'b000,
      EXT_ZERO = 3'b001,
      EXT_LUI  = 3'b010,
      EXT_BOFF = 3'b011,
      EXT_LB   = 3'b100,
      EXT_LBU  = 3'b101,
      EXT_LH   = 3'b110,
      EXT_LHU  = 3'b111
   } ext_op_e;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   localparam int MAX_W = 64;

   // Returns {err, data}; data is masked to data_w bits. Widths must be
   // constants at the call site so this folds into plain muxing.
   function automatic logic [MAX_W:0] ext_calc(
      input ext_op_e          op,
      input logic [MAX_W-1:0] data,
      input logic [2:0]       off,
      input int               imm_w,
      input int               data_w
   );
      logic [MAX_W-1:0]        imm_z;
      logic signed [MAX_W-1:0] imm_s;
      logic [MAX_W-1:0]        lane;
      logic [MAX_W-1:0]        res;
      logic                    err;
      imm_z = data & ((64'd1 << imm_w) - 64'd1);
      imm_s = $signed(data << (MAX_W - imm_w)) >>> (MAX_W - imm_w);
      lane  = '0;
      res   = '0;
      err   = 1'b0;
      unique case (op)
         EXT_SIGN: res = imm_s;
         EXT_ZERO: res = imm_z;
         EXT_LUI:  res = imm_z << (data_w - imm_w);
         EXT_BOFF: res = imm_s << 2;
         EXT_LB, EXT_LBU: begin
            lane = (data >> {off, 3'b000}) & 64'hFF;
            res  = (op == EXT_LB && lane[7]) ? (lane | ~64'hFF) : lane;
         end
         EXT_LH, EXT_LHU: begin
            // Odd offset for a halfword is flagged, data forced to zero.
            if (off[0]) begin
               err = 1'b1;
            end else begin
               lane = (data >> {off[2:1], 4'b0000}) & 64'hFFFF;
               res  = (op == EXT_LH && lane[15]) ? (lane | ~64'hFFFF) : lane;
            end
         end
      endcase
      // For data_w == 64 the shift wraps to 0 and the mask becomes all ones.
      res = res & ((64'd1 << data_w) - 64'd1);
      return {err, res};
   endfunction

endpackage

// File: rtl/ext_skid.sv
// ext_skid: 2-entry valid/ready skid buffer (output register + skid
// register). in_ready is registered so it has no path from out_ready.
module ext_skid
   import ext_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_reg, state_next;
   logic [W-1:0] out_reg, skid_reg;
   logic         ready_reg;
   logic         accept, drain;
   logic         load_out, load_skid, move_skid;

   assign accept    = in_valid && ready_reg;
   assign drain     = (state_reg != SKID_EMPTY) && out_ready;
   assign in_ready  = ready_reg;
   assign out_valid = (state_reg != SKID_EMPTY);
   assign out_data  = out_reg;

   // Next state and register load controls; accept+drain in ONE replaces the output entry.
   always_comb begin
      state_next = state_reg;
      load_out   = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
      case (state_reg)
         SKID_EMPTY: begin
            if (accept) begin
               state_next = SKID_ONE;
               load_out   = 1'b1;
            end
         end
         SKID_ONE: begin
            if (accept && drain) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_next = SKID_FULL;
               load_skid  = 1'b1;
            end else if (drain) begin
               state_next = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (drain) begin
               state_next = SKID_ONE;
               move_skid  = 1'b1;
            end
         end
         default: state_next = SKID_EMPTY;
      endcase
   end

   // State, data entries and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= SKID_EMPTY;
         out_reg   <= '0;
         skid_reg  <= '0;
         ready_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != SKID_FULL);
         if (load_out) begin
            out_reg <= in_data;
         end else if (move_skid) begin
            out_reg <= skid_reg;
         end
         if (load_skid) begin
            skid_reg <= in_data;
         end
      end
   end

endmodule

// File: rtl/ext_unit.sv
// ext_unit: pipelined immediate / load-data extender, one-cycle latency,
// valid/ready on both sides through a 2-entry skid buffer.
// Optional statistics counters are built when EXT_STATS_EN is defined.
module ext_unit
   import ext_pkg::*;
#(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8),
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_off,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  stat_ops,
   output logic [CNT_W-1:0]  stat_errs
);

   logic [MAX_W:0]  calc;
   logic [DATA_W:0] ext_word;
   logic [DATA_W:0] skid_out;

   assign calc     = ext_calc(ext_op_e'(in_op), MAX_W'(in_data), 3'(in_off), IMM_W, DATA_W);
   assign ext_word = {calc[MAX_W], calc[DATA_W-1:0]};

   generate
      if (DATA_W < MAX_W) begin : g_pad
         logic unused_hi;
         assign unused_hi = ^calc[MAX_W-1:DATA_W];
      end
   endgenerate

   ext_skid #(.W(DATA_W+1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (ext_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (skid_out)
   );

   assign out_data = skid_out[DATA_W-1:0];
   assign out_err  = skid_out[DATA_W];

`ifdef EXT_STATS_EN
   logic             accept;
   logic [CNT_W-1:0] ops_reg, errs_reg;

   assign accept    = in_valid && in_ready;
   assign stat_ops  = ops_reg;
   assign stat_errs = errs_reg;

   // Saturating counts of accepted transactions and accepted misaligned halfwords.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_reg  <= '0;
         errs_reg <= '0;
      end else if (accept) begin
         if (ops_reg != '1) begin
            ops_reg <= ops_reg + 1'b1;
         end
         if (ext_word[DATA_W] && errs_reg != '1) begin
            errs_reg <= errs_reg + 1'b1;
         end
      end
   end
`else
   assign stat_ops  = '0;
   assign stat_errs = '0;
`endif

endmodule
